// File: rtl/mult_tile_sched.sv
// Tile sequencer for the 2x2-tile matrix multiplier.
// Latches two NxN signed matrices, feeds row/column pairs tile by tile to an
// external multiplier and collects the four products of each tile into a flat
// result matrix, while accumulating the multiplier overflow flag.
module mult_tile_sched #(
    parameter int N        = 5,
    parameter int W        = 8,
    parameter int MULT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*N*W-1:0]     m1,
    input  logic [N*N*W-1:0]     m2,
    output logic [2*N*W-1:0]     lin,
    output logic [2*N*W-1:0]     col,
    input  logic [4*W-1:0]       n_out,
    input  logic                 mult_ovf,
    output logic [N*N*W-1:0]     result,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    // Tile counters must hold N+1 after the final advance.
    localparam int CW = $clog2(N + 3);
    localparam int LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     ti;
    logic [CW-1:0]     tj;
    logic [LW-1:0]     wcnt;
    logic [N*N*W-1:0]  a_q;
    logic [N*N*W-1:0]  b_q;
    logic              last_tile;

    // Row idx of a packed matrix; idx == N is the odd-N padding row (all zero).
    function automatic logic [N*W-1:0] get_row(input logic [N*N*W-1:0] mat, input int idx);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (idx < N) begin
                v[W*k +: W] = mat[W*(N*idx + k) +: W];
            end
        end
        return v;
    endfunction

    // Column idx of a packed matrix; idx == N yields the zero padding column.
    function automatic logic [N*W-1:0] get_col(input logic [N*N*W-1:0] mat, input int idx);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (idx < N) begin
                v[W*k +: W] = mat[W*(N*k + idx) +: W];
            end
        end
        return v;
    endfunction

    // The tile being stored is the last one when both counters are on the final pair.
    assign last_tile = (int'(ti) + 2 >= N) && (int'(tj) + 2 >= N);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy      = 1'b1;
                state_nxt = (MULT_LAT > 0) ? S_WAIT : S_STORE;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt == '0) begin
                    state_nxt = S_STORE;
                end
            end
            S_STORE: begin
                busy      = 1'b1;
                state_nxt = last_tile ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand snapshot: only an accepted start updates the working copies.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            a_q <= m1;
            b_q <= m2;
        end
    end

    // Tile walk, operand issue, latency countdown and result collection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ti     <= '0;
            tj     <= '0;
            wcnt   <= '0;
            lin    <= '0;
            col    <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ti     <= '0;
                        tj     <= '0;
                        result <= '0;
                        ovf    <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    lin  <= {get_row(a_q, int'(ti) + 1), get_row(a_q, int'(ti))};
                    col  <= {get_col(b_q, int'(tj) + 1), get_col(b_q, int'(tj))};
                    wcnt <= LW'(MULT_LAT - 1);
                end
                S_WAIT: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - LW'(1);
                    end
                end
                S_STORE: begin
                    // n_out is MSB first: (i,j), (i,j+1), (i+1,j), (i+1,j+1).
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            if (int'(ti) + dr < N && int'(tj) + dc < N) begin
                                result[W*(N*(int'(ti) + dr) + int'(tj) + dc) +: W]
                                    <= n_out[W*(3 - 2*dr - dc) +: W];
                            end
                        end
                    end
                    ovf <= ovf | mult_ovf;
                    if (int'(tj) + 2 >= N) begin
                        tj <= '0;
                        ti <= ti + CW'(2);
                    end else begin
                        tj <= tj + CW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_tile_sched.sv
// Self-checking bench for mult_tile_sched with a behavioural 1-cycle multiplier.
module tb_mult_tile_sched;

    localparam int N      = 5;
    localparam int W      = 8;
    localparam int ML     = 1;
    localparam int PER    = 2 + ML;
    localparam int TILES  = ((N + 1) / 2) * ((N + 1) / 2);
    localparam int DONE_N = 1 + TILES * PER;

    typedef logic [N*N*W-1:0] mat_t;

    logic             clk;
    logic             rst;
    logic             start;
    mat_t             m1;
    mat_t             m2;
    logic [2*N*W-1:0] lin;
    logic [2*N*W-1:0] col;
    logic [4*W-1:0]   n_out;
    logic             mult_ovf;
    mat_t             result;
    logic             ovf;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    mult_tile_sched #(.N(N), .W(W), .MULT_LAT(ML)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .m1       (m1),
        .m2       (m2),
        .lin      (lin),
        .col      (col),
        .n_out    (n_out),
        .mult_ovf (mult_ovf),
        .result   (result),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int el(input mat_t m, input int r, input int c);
        logic signed [W-1:0] v;
        v = m[W*(N*r + c) +: W];
        return int'(v);
    endfunction

    function automatic mat_t set_el(input mat_t m, input int r, input int c, input int v);
        mat_t o;
        logic [31:0] t;
        o = m;
        t = v;
        o[W*(N*r + c) +: W] = t[W-1:0];
        return o;
    endfunction

    // Reference: plain matrix product, wrapped to W bits.
    function automatic mat_t ref_mul(input mat_t a, input mat_t b);
        mat_t o;
        o = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int s;
                s = 0;
                for (int k = 0; k < N; k++) s += el(a, r, k) * el(b, k, c);
                o = set_el(o, r, c, s);
            end
        end
        return o;
    endfunction

    function automatic mat_t rand_mat();
        mat_t o;
        o = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                o = set_el(o, r, c, int'($urandom_range(255)));
        return o;
    endfunction

    function automatic mat_t fill_mat(input int v);
        mat_t o;
        o = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                o = set_el(o, r, c, v);
        return o;
    endfunction

    // Expected vector contents: row r / column c, zero for the padding index N.
    function automatic logic [N*W-1:0] exp_row(input mat_t m, input int r);
        logic [N*W-1:0] v;
        logic [31:0]    t;
        v = '0;
        for (int k = 0; k < N; k++) begin
            t = (r < N) ? el(m, r, k) : 0;
            v[W*k +: W] = t[W-1:0];
        end
        return v;
    endfunction

    function automatic logic [N*W-1:0] exp_col(input mat_t m, input int c);
        logic [N*W-1:0] v;
        logic [31:0]    t;
        v = '0;
        for (int k = 0; k < N; k++) begin
            t = (c < N) ? el(m, k, c) : 0;
            v[W*k +: W] = t[W-1:0];
        end
        return v;
    endfunction

    // Behavioural multiplier: 2x2 dot products of the presented vectors, one cycle later.
    function automatic logic [4*W-1:0] mult_model(input logic [2*N*W-1:0] l, input logic [2*N*W-1:0] cv);
        logic [4*W-1:0] o;
        o = '0;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                int s;
                logic [31:0] t;
                logic signed [W-1:0] x;
                logic signed [W-1:0] y;
                s = 0;
                for (int k = 0; k < N; k++) begin
                    x = l[N*W*a + W*k +: W];
                    y = cv[N*W*b + W*k +: W];
                    s += int'(x) * int'(y);
                end
                t = s;
                o[W*(3 - 2*a - b) +: W] = t[W-1:0];
            end
        end
        return o;
    endfunction

    always @(posedge clk) n_out <= mult_model(lin, col);

    // One full operation; mult_ovf is raised during the store cycle of tile ovf_tile (-1: never).
    task automatic run_op(input string name, input mat_t a, input mat_t b, input int ovf_tile, input bit poke);
        mat_t exp;
        exp = ref_mul(a, b);
        @(negedge clk);
        m1 = a;
        m2 = b;
        start = 1'b1;
        for (int n = 1; n <= DONE_N + 2; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 1) begin
                m1 = rand_mat();
                m2 = rand_mat();
                chk({name, "_ovf_clr"}, 256'(ovf), 256'(1'b0));
                chk({name, "_res_clr"}, 256'(result), 256'(0));
            end
            if (n == 2) begin
                chk({name, "_lin0"}, 256'(lin), 256'({exp_row(a, 1), exp_row(a, 0)}));
                chk({name, "_col0"}, 256'(col), 256'({exp_col(b, 1), exp_col(b, 0)}));
            end
            if (n == (TILES - 1) * PER + 2) begin
                chk({name, "_lin_last"}, 256'(lin), 256'({exp_row(a, N), exp_row(a, N - 1)}));
                chk({name, "_col_last"}, 256'(col), 256'({exp_col(b, N), exp_col(b, N - 1)}));
            end
            if (poke && (n == 5 || n == DONE_N)) start = 1'b1;
            mult_ovf = (ovf_tile >= 0) && (n == ovf_tile * PER + PER);
            chk({name, "_busy"}, 256'(busy), 256'(n >= 1 && n < DONE_N));
            chk({name, "_done"}, 256'(done), 256'(n == DONE_N));
            if (n >= DONE_N) begin
                chk({name, "_result"}, 256'(result), 256'(exp));
                chk({name, "_ovf"}, 256'(ovf), 256'(ovf_tile >= 0));
            end
        end
        mult_ovf = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_reset(input mat_t a, input mat_t b);
        @(negedge clk);
        m1 = a;
        m2 = b;
        start = 1'b1;
        for (int n = 1; n < 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_lin",    256'(lin),    256'(0));
        chk("rst_mid_col",    256'(col),    256'(0));
        chk("rst_mid_result", 256'(result), 256'(0));
        chk("rst_mid_ovf",    256'(ovf),    256'(0));
        chk("rst_mid_busy",   256'(busy),   256'(0));
        chk("rst_mid_done",   256'(done),   256'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("rst_after_busy", 256'(busy), 256'(0));
            chk("rst_after_done", 256'(done), 256'(0));
        end
    endtask

    initial begin
        mat_t ident;
        mat_t seq;
        mat_t ra;
        mat_t rb;
        rst      = 1'b1;
        start    = 1'b0;
        m1       = '0;
        m2       = '0;
        mult_ovf = 1'b0;
        n_out    = '0;

        repeat (2) @(negedge clk);
        chk("reset_lin",    256'(lin),    256'(0));
        chk("reset_col",    256'(col),    256'(0));
        chk("reset_result", 256'(result), 256'(0));
        chk("reset_ovf",    256'(ovf),    256'(0));
        chk("reset_busy",   256'(busy),   256'(0));
        chk("reset_done",   256'(done),   256'(0));
        rst = 1'b0;
        @(negedge clk);

        ident = '0;
        seq   = '0;
        for (int r = 0; r < N; r++) begin
            ident = set_el(ident, r, r, 1);
            for (int c = 0; c < N; c++) seq = set_el(seq, r, c, N * r + c);
        end

        run_op("t1", ident, seq, -1, 1'b0);
        chk("t1_res_eq_m2", 256'(result), 256'(seq));

        run_op("t2", fill_mat(2), fill_mat(2), -1, 1'b0);
        chk("t2_elem20", 256'(result[W*7 +: W]), 256'(8'd20));

        run_op("t3", fill_mat(127), fill_mat(127), 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_ovf_held", 256'(ovf), 256'(1'b1));

        run_op("t4", rand_mat(), rand_mat(), -1, 1'b1);
        run_op("t4b", ident, seq, -1, 1'b0);

        run_reset(fill_mat(3), fill_mat(5));
        run_op("t5", ident, seq, -1, 1'b0);

        ra = rand_mat();
        rb = rand_mat();
        run_op("t6", ra, rb, -1, 1'b0);
        begin
            int s00;
            int s44;
            logic [31:0] t;
            s00 = 0;
            s44 = 0;
            for (int k = 0; k < N; k++) begin
                s00 += el(ra, 0, k) * el(rb, k, 0);
                s44 += el(ra, N - 1, k) * el(rb, k, N - 1);
            end
            t = s00;
            chk("t6_elem00", 256'(result[0 +: W]), 256'(t[W-1:0]));
            t = s44;
            chk("t6_elem44", 256'(result[W*(N*N - 1) +: W]), 256'(t[W-1:0]));
        end

        for (int i = 0; i < 4; i++) begin
            int ot;
            ot = int'($urandom_range(TILES)) - 1;
            run_op("rand", rand_mat(), rand_mat(), ot, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
